free_list: RTL and testbench

Physical-register free list for the rename stage. It supplies up to `N_WAY` free physical tags per cycle to the map table on `pr_freelist` and accepts up to `N_WAY` released tags per cycle from ROB retirement (the `pr_old`/Told values recorded at dispatch). It is a circular buffer with a speculative head, a retirement head and a tail. On `branch_haz` it restores to the architectural free set in one cycle, matching the map table's restore from `arch_reg`.

---
 rtl/free_list.sv | 117 +++++++++++
 tb/tb_free_list.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Physical-register free list for rename: a circular buffer of free tags with a
// speculative pop head, a retirement head for mispredict recovery, and a push tail.
module free_list #(
    parameter int N_WAY    = 2,
    parameter int CDB_BITS = 6,
    parameter int XLEN     = 32,
    parameter int PRF_SIZE = 64,
    parameter int FL_DEPTH = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_WAY-1:0]               dis_req,
    input  logic [N_WAY-1:0]               retire_valid,
    input  logic [N_WAY-1:0][CDB_BITS-1:0] retire_told,
    input  logic                           branch_haz,
    output logic [N_WAY-1:0][CDB_BITS-1:0] pr_freelist,
    output logic [$clog2(FL_DEPTH):0]      free_count,
    output logic                           fl_overflow
);
    localparam int PW  = $clog2(FL_DEPTH);
    localparam int CW  = PW + 1;
    localparam int CAP = PRF_SIZE - 1 - XLEN;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   spc_t;

    logic [CDB_BITS-1:0] slot_q [FL_DEPTH];
    logic [CDB_BITS-1:0] slot_d [FL_DEPTH];
    ptr_t head_q, head_d;
    ptr_t rhead_q, rhead_d;
    ptr_t tail_q, tail_d;
    cnt_t count_q, count_d;
    logic overflow_q, overflow_d;

    cnt_t reqs, pops, pops_eff, pushes;
    spc_t space;
    ptr_t rd_idx, wr_idx;

    // Lane n reads at head + (requests in lower lanes); once the list runs dry
    // every later requesting lane sees 0 and must stall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        reqs        = '0;
        pops        = '0;
        rd_idx      = '0;
        pr_freelist = '0;
        for (int n = 0; n < N_WAY; n++) begin
            if (dis_req[n]) begin
                if (reqs < count_q) begin
                    rd_idx         = head_q + reqs[PW-1:0];
                    pr_freelist[n] = slot_q[rd_idx];
                    pops           = pops + cnt_t'(1);
                end
                reqs = reqs + cnt_t'(1);
            end
        end
    end

    always_comb begin
        pops_eff   = branch_haz ? cnt_t'(0) : pops;
        space      = spc_t'(CAP) - {1'b0, count_q} + {1'b0, pops_eff};
        pushes     = '0;
        wr_idx     = '0;
        overflow_d = overflow_q;
        slot_d     = slot_q;
        // Told 0 means "no tag" and is never released; excess pushes are dropped.
        for (int n = 0; n < N_WAY; n++) begin
            if (retire_valid[n] && (retire_told[n] != '0)) begin
                if ({1'b0, pushes} < space) begin
                    wr_idx         = tail_q + pushes[PW-1:0];
                    slot_d[wr_idx] = retire_told[n];
                    pushes         = pushes + cnt_t'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end

        rhead_d = rhead_q + pushes[PW-1:0];
        tail_d  = tail_q + pushes[PW-1:0];
        if (branch_haz) begin
            // Everything between the retirement head and the tail is free again.
            head_d  = rhead_d;
            count_d = {1'b0, tail_d - rhead_d};
        end else begin
            head_d  = head_q + pops[PW-1:0];
            count_d = count_q + pushes - pops;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the slot array is reset on purpose: the reset image defines the initial free tags.
            for (int i = 0; i < FL_DEPTH; i++) begin
                slot_q[i] <= (i < CAP) ? CDB_BITS'(XLEN + 1 + i) : '0;
            end
            head_q     <= '0;
            rhead_q    <= '0;
            tail_q     <= ptr_t'(CAP);
            count_q    <= cnt_t'(CAP);
            overflow_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            slot_q     <= slot_d;
            head_q     <= head_d;
            rhead_q    <= rhead_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign free_count  = count_q;
    assign fl_overflow = overflow_q;

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed boundary steps plus a randomized
// alloc/retire/recover run, checked against a queue-based model of the free set.
module tb_free_list;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      dis_req;
    logic [1:0]      retire_valid;
    logic [1:0][5:0] retire_told;
    logic            branch_haz;
    logic [1:0][5:0] pr_freelist;
    logic [5:0]      free_count;
    logic            fl_overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Model: free_q holds free tags in grant order, rob_q holds granted but not
    // yet retired tags in allocation order; arch_q is the random generator's
    // architectural mapping (oldest mapping is overwritten first).
    int free_q[$];
    int rob_q[$];
    int arch_q[$];
    bit m_ovf;
    bit chk_dup = 1'b0;

    free_list dut (
        .clock        (clock),
        .reset        (reset),
        .dis_req      (dis_req),
        .retire_valid (retire_valid),
        .retire_told  (retire_told),
        .branch_haz   (branch_haz),
        .pr_freelist  (pr_freelist),
        .free_count   (free_count),
        .fl_overflow  (fl_overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        for (int i = 0; i < 31; i++) free_q.push_back(33 + i);
        rob_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic reset_cycle(input logic [1:0] dis, input logic [1:0] rv);
        @(negedge clock);
        reset          = 1'b1;
        dis_req        = dis;
        retire_valid   = rv;
        retire_told[0] = 6'd11;
        retire_told[1] = 6'd12;
        branch_haz     = 1'b0;
        @(posedge clock);
        model_reset();
        #1;
        check("rst_free_count", 32'(free_count), 31);
        check("rst_overflow", 32'(fl_overflow), 0);
    endtask

    // One clock: drive at negedge, check grants, commit at posedge, check state.
    task automatic step(input logic [1:0] dis, input logic [1:0] rv, input int t0, input int t1,
                        input logic haz, input int e0 = -1, input int e1 = -1);
        int exp_g[2];
        int tl[2];
        int k;
        int pops;
        int cnt;
        int acc[$];
        @(negedge clock);
        reset          = 1'b0;
        dis_req        = dis;
        retire_valid   = rv;
        retire_told[0] = 6'(t0);
        retire_told[1] = 6'(t1);
        branch_haz     = haz;
        tl[0] = t0;
        tl[1] = t1;
        k = 0;
        for (int n = 0; n < 2; n++) begin
            exp_g[n] = 0;
            if (dis[n] && k < free_q.size()) begin
                exp_g[n] = free_q[k];
                k++;
            end
        end
        #1;
        for (int n = 0; n < 2; n++) check($sformatf("grant%0d", n), 32'(pr_freelist[n]), exp_g[n]);
        if (e0 >= 0) check("grant0_const", 32'(pr_freelist[0]), e0);
        if (e1 >= 0) check("grant1_const", 32'(pr_freelist[1]), e1);
        if (chk_dup) begin
            for (int n = 0; n < 2; n++) begin
                if (pr_freelist[n] != 6'd0) begin
                    cnt = 0;
                    foreach (rob_q[i])  if (rob_q[i]  == int'(pr_freelist[n])) cnt++;
                    foreach (arch_q[i]) if (arch_q[i] == int'(pr_freelist[n])) cnt++;
                    check($sformatf("dup_grant%0d", n), cnt, 0);
                end
            end
        end
        @(posedge clock);
        pops = haz ? 0 : k;
        for (int n = 0; n < 2; n++) begin
            if (rv[n] && tl[n] != 0) begin
                if (free_q.size() - pops + acc.size() < 31) acc.push_back(tl[n]);
                else m_ovf = 1'b1;
            end
        end
        for (int i = 0; i < pops; i++) rob_q.push_back(free_q.pop_front());
        for (int i = 0; i < acc.size(); i++) if (rob_q.size() > 0) void'(rob_q.pop_front());
        if (haz) begin
            free_q = {rob_q, free_q};
            rob_q.delete();
        end
        foreach (acc[i]) free_q.push_back(acc[i]);
        #1;
        check("free_count", 32'(free_count), free_q.size());
        check("fl_overflow", 32'(fl_overflow), 32'(m_ovf));
    endtask

    initial begin
        logic [1:0] d;
        logic [1:0] r;
        logic       h;
        int         tl[2];
        int         nret;
        int         j;

        reset        = 1'b1;
        dis_req      = '0;
        retire_valid = '0;
        retire_told  = '0;
        branch_haz   = 1'b0;

        // Two-lane grant straight out of reset.
        reset_cycle(2'b00, 2'b00);
        step(2'b11, 2'b00, 0, 0, 1'b0, 33, 34);
        check("after_pair_count", 32'(free_count), 29);

        // Only lane 1 requests: it takes the head tag.
        reset_cycle(2'b00, 2'b00);
        step(2'b10, 2'b00, 0, 0, 1'b0, 0, 33);
        check("lane1_only_count", 32'(free_count), 30);

        // Drain to one entry, exhaust with a same-cycle retire, then empty.
        for (int i = 0; i < 14; i++) step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b01, 2'b00, 0, 0, 1'b0);
        check("drained_count", 32'(free_count), 1);
        step(2'b11, 2'b01, 5, 0, 1'b0, 63, 0);
        step(2'b01, 2'b00, 0, 0, 1'b0, 5, -1);
        step(2'b11, 2'b00, 0, 0, 1'b0, 0, 0);
        check("empty_count", 32'(free_count), 0);

        // Mispredict recovery, then drain across the pointer wrap.
        reset_cycle(2'b00, 2'b00);
        for (int i = 0; i < 5; i++) step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b11, 1, 2, 1'b0);
        step(2'b00, 2'b11, 3, 4, 1'b0);
        step(2'b11, 2'b01, 6, 0, 1'b1);
        check("recover_count", 32'(free_count), 31);
        step(2'b01, 2'b00, 0, 0, 1'b0, 38, -1);
        for (int i = 0; i < 12; i++) step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b0, 63, 1);
        step(2'b11, 2'b00, 0, 0, 1'b0, 2, 3);
        step(2'b11, 2'b00, 0, 0, 1'b0, 4, 6);

        // Told 0 is ignored; a push into a full list sets the sticky flag.
        reset_cycle(2'b00, 2'b00);
        step(2'b01, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b11, 0, 9, 1'b0);
        check("told0_count", 32'(free_count), 31);
        check("told0_no_overflow", 32'(fl_overflow), 0);
        step(2'b00, 2'b01, 8, 0, 1'b0);
        check("overflow_set", 32'(fl_overflow), 1);
        step(2'b00, 2'b00, 0, 0, 1'b0);
        check("overflow_sticky", 32'(fl_overflow), 1);

        // Randomized alloc/retire/recover with architectural bookkeeping.
        reset_cycle(2'b00, 2'b00);
        arch_q.delete();
        for (int i = 1; i <= 32; i++) arch_q.push_back(i);
        chk_dup = 1'b1;
        for (int c = 0; c < 300; c++) begin
            d    = 2'($urandom_range(0, 3));
            h    = ($urandom_range(0, 15) == 0);
            nret = $urandom_range(0, 2);
            if (nret > rob_q.size()) nret = rob_q.size();
            if (nret == 2) r = 2'b11;
            else if (nret == 1) r = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            else r = 2'b00;
            j = 0;
            for (int n = 0; n < 2; n++) begin
                tl[n] = 0;
                if (r[n]) begin
                    tl[n] = arch_q.pop_front();
                    arch_q.push_back(rob_q[j]);
                    j++;
                end
            end
            step(d, r, tl[0], tl[1], h);
            check("conservation", 32'(free_count) + 32'(rob_q.size()) + 32'(arch_q.size()), 63);
        end
        chk_dup = 1'b0;

        // Reset while dispatch and retire are both active.
        reset_cycle(2'b11, 2'b11);
        step(2'b11, 2'b00, 0, 0, 1'b0, 33, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
